// File: rtl/sram_adder_datapath_if.sv
// Bus between the multi-word adder controller/SRAM side and the datapath.
// The master drives the control and SRAM read signals; the slave (the datapath)
// drives the address, status and result-write signals.
interface sram_adder_datapath_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    // Controller / SRAM to datapath
    logic              load;
    logic [ADDR_W-1:0] len;
    logic              first;
    logic              sel;
    logic              addr_minus_en;
    logic              sram_rvalid;
    logic [DATA_W-1:0] sram_rdata;

    // Datapath to controller / SRAM / result memory
    logic [ADDR_W:0]   sram_addr;
    logic              zero;
    logic              res_we;
    logic [ADDR_W-1:0] res_addr;
    logic [DATA_W-1:0] res_data;
    logic              carry_out;
    logic              done;
    logic              err;

    modport master (
        output load, len, first, sel, addr_minus_en, sram_rvalid, sram_rdata,
        input  sram_addr, zero, res_we, res_addr, res_data, carry_out, done, err
    );

    modport slave (
        input  load, len, first, sel, addr_minus_en, sram_rvalid, sram_rdata,
        output sram_addr, zero, res_we, res_addr, res_data, carry_out, done, err
    );
endinterface

// File: rtl/sram_adder_datapath.sv
// Word-serial adder datapath. Operands live in two SRAM banks (A, B); words
// are walked from index len (least significant) down to index 0 (most
// significant). Each A read is held in op_a, each B read is added to it with
// the running carry and written out as one result word.
module sram_adder_datapath #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    sram_adder_datapath_if.slave  bus
);
    localparam logic [ADDR_W-1:0] IDX_ONE = ADDR_W'(1);

    logic [ADDR_W-1:0] r_idx;
    logic [DATA_W-1:0] r_op_a;
    logic              r_carry;
    logic              r_first_q;
    logic              r_res_we;
    logic [ADDR_W-1:0] r_res_addr;
    logic [DATA_W-1:0] r_res_data;
    logic              r_carry_out;
    logic              r_done;
    logic              r_err;

    logic              w_idx_zero;
    logic              w_a_capture;
    logic              w_b_sum;
    logic              w_cin;
    logic [DATA_W:0]   w_sum;

    // Carry-in is suppressed on the first word of an operation, whether the
    // controller flags it this cycle or it was flagged earlier (load/first).
    always_comb begin
        w_idx_zero  = (r_idx == '0);
        w_a_capture = bus.sram_rvalid & bus.sel;
        w_b_sum     = bus.sram_rvalid & ~bus.sel;
        w_cin       = (r_first_q | bus.first) ? 1'b0 : r_carry;
        w_sum       = {1'b0, r_op_a} + {1'b0, bus.sram_rdata}
                    + {{DATA_W{1'b0}}, w_cin};
    end

    // Word index, carry chain, operand hold and result registers; load wins
    // over any concurrent read data so a stale sum never reaches the output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx       <= '0;
            r_op_a      <= '0;
            r_carry     <= 1'b0;
            r_first_q   <= 1'b1;
            r_res_we    <= 1'b0;
            r_res_addr  <= '0;
            r_res_data  <= '0;
            r_carry_out <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else if (bus.load) begin
            r_idx     <= bus.len;
            r_carry   <= 1'b0;
            r_first_q <= 1'b1;
            r_err     <= 1'b0;
            r_res_we  <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_res_we <= w_b_sum;
            r_done   <= w_b_sum & w_idx_zero;

            if (w_a_capture) begin
                r_op_a <= bus.sram_rdata;
            end

            if (w_b_sum) begin
                r_res_data <= w_sum[DATA_W-1:0];
                r_res_addr <= r_idx;
                r_carry    <= w_sum[DATA_W];
                r_first_q  <= 1'b0;
                if (w_idx_zero) begin
                    r_carry_out <= w_sum[DATA_W];
                end
            end else if (bus.first) begin
                r_first_q <= 1'b1;
            end

            // Index saturates at 0; an attempt to go below it is flagged.
            if (bus.addr_minus_en) begin
                if (w_idx_zero) begin
                    r_err <= 1'b1;
                end else begin
                    r_idx <= r_idx - IDX_ONE;
                end
            end
        end
    end

    // Bank select is inverted: sel=1 (A phase) addresses bank 0.
    always_comb begin
        bus.sram_addr = {~bus.sel, r_idx};
        bus.zero      = w_idx_zero;
        bus.res_we    = r_res_we;
        bus.res_addr  = r_res_addr;
        bus.res_data  = r_res_data;
        bus.carry_out = r_carry_out;
        bus.done      = r_done;
        bus.err       = r_err;
    end
endmodule

// File: tb/tb_sram_adder_datapath.sv
// Scoreboard bench for sram_adder_datapath: each multi-word addition is
// computed as one wide integer sum, sliced into expected result words and
// queued; a negedge monitor pops and compares every result write.
module tb_sram_adder_datapath;
    localparam int DW = 8;
    localparam int AW = 4;

    typedef struct {
        int addr;
        int data;
        bit last;
        bit cout;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    logic [7:0] wa[16];
    logic [7:0] wb[16];

    sram_adder_datapath_if #(.DATA_W(DW), .ADDR_W(AW)) bus();

    sram_adder_datapath #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", nm, act);
        end
    endtask

    // Drive one cycle of controller/SRAM signals, return 1 time unit past the edge.
    task automatic step(input bit ld, input int ln, input bit fi, input bit se,
                        input bit am, input bit rv, input int rd);
        bus.load          = ld;
        bus.len           = ln[3:0];
        bus.first         = fi;
        bus.sel           = se;
        bus.addr_minus_en = am;
        bus.sram_rvalid   = rv;
        bus.sram_rdata    = rd[7:0];
        @(posedge clk);
        #1;
        bus.load          = 1'b0;
        bus.first         = 1'b0;
        bus.addr_minus_en = 1'b0;
        bus.sram_rvalid   = 1'b0;
    endtask

    task automatic idle();
        step(0, 0, 0, 1, 0, 0, 0);
    endtask

    // Full addition of wa/wb words 0..L (index 0 most significant).
    task automatic do_add(input int L, input bit gaps);
        logic [135:0] av, bv, tot;
        exp_t e;
        av = '0;
        bv = '0;
        for (int i = 0; i <= L; i++) begin
            av = av | (136'(wa[i]) << (8 * (L - i)));
            bv = bv | (136'(wb[i]) << (8 * (L - i)));
        end
        tot = av + bv;
        for (int i = L; i >= 0; i--) begin
            e.addr = i;
            e.data = int'(tot[8*(L-i) +: 8]);
            e.last = (i == 0);
            e.cout = tot[8*(L+1)];
            sb.push_back(e);
        end
        step(1, L, 0, 1, 0, 0, 0);
        for (int i = L; i >= 0; i--) begin
            bus.sel = 1'b1;
            #1;
            chk("sram_addr_a", 32'(bus.sram_addr), 32'({1'b0, i[3:0]}));
            if (gaps && ($urandom % 3 == 0)) idle();
            step(0, 0, 0, 1, 0, 1, int'(wa[i]));
            if (gaps && ($urandom % 3 == 0)) idle();
            bus.sel = 1'b0;
            #1;
            chk("sram_addr_b", 32'(bus.sram_addr), 32'({1'b1, i[3:0]}));
            step(0, 0, 0, 0, (i > 0), 1, int'(wb[i]));
        end
    endtask

    // Monitor: every result write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.res_we) begin
                if (sb.size() == 0) begin
                    chk("unexpected_res_we", 32'(bus.res_we), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("res_addr", 32'(bus.res_addr), 32'(e.addr));
                    chk("res_data", 32'(bus.res_data), 32'(e.data));
                    chk("done", 32'(bus.done), 32'(e.last));
                    if (e.last) chk("carry_out", 32'(bus.carry_out), 32'(e.cout));
                end
            end else if (bus.done) begin
                chk("done_without_res_we", 32'(bus.done), 32'd0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        bus.load = 0; bus.len = 0; bus.first = 0; bus.sel = 1;
        bus.addr_minus_en = 0; bus.sram_rvalid = 0; bus.sram_rdata = 0;
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        chk("rst_res_we",    32'(bus.res_we), 32'd0);
        chk("rst_done",      32'(bus.done), 32'd0);
        chk("rst_err",       32'(bus.err), 32'd0);
        chk("rst_zero",      32'(bus.zero), 32'd1);
        chk("rst_carry_out", 32'(bus.carry_out), 32'd0);
        chk("rst_res_data",  32'(bus.res_data), 32'd0);
        chk("rst_res_addr",  32'(bus.res_addr), 32'd0);
        chk("rst_sram_addr", 32'(bus.sram_addr), 32'd0);
        reset = 1'b0;
        idle();

        // One word: 0xFF + 0x01
        wa[0] = 8'hFF; wb[0] = 8'h01;
        do_add(0, 0);
        idle();

        // Reset between A and B reads
        e = '{addr: 2, data: 8'h46, last: 0, cout: 0};
        sb.push_back(e);
        step(1, 2, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 1, 8'h12);
        step(0, 0, 0, 0, 1, 1, 8'h34);
        step(0, 0, 0, 1, 0, 1, 8'h55);
        reset = 1'b1;
        #1;
        chk("arst_res_we",    32'(bus.res_we), 32'd0);
        chk("arst_done",      32'(bus.done), 32'd0);
        chk("arst_res_data",  32'(bus.res_data), 32'd0);
        chk("arst_res_addr",  32'(bus.res_addr), 32'd0);
        chk("arst_carry_out", 32'(bus.carry_out), 32'd0);
        chk("arst_zero",      32'(bus.zero), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        e = '{addr: 0, data: 8'h9C, last: 1, cout: 0};
        sb.push_back(e);
        step(0, 0, 0, 0, 0, 1, 8'h9C);
        idle();

        // Two words with carry propagation
        wa[1] = 8'hF0; wa[0] = 8'h01; wb[1] = 8'h20; wb[0] = 8'h02;
        do_add(1, 0);
        idle();

        // Decrement saturates at zero and flags err
        step(1, 1, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 1, 0, 0);
        chk("dec1_idx", 32'(bus.sram_addr), 32'd0);
        chk("dec1_err", 32'(bus.err), 32'd0);
        step(0, 0, 0, 1, 1, 0, 0);
        chk("dec2_idx", 32'(bus.sram_addr), 32'd0);
        chk("dec2_err", 32'(bus.err), 32'd1);
        step(0, 0, 0, 1, 1, 0, 0);
        chk("dec3_idx", 32'(bus.sram_addr), 32'd0);
        chk("dec3_zero", 32'(bus.zero), 32'd1);
        chk("dec3_err", 32'(bus.err), 32'd1);

        // Load coincident with B-phase read data: sum discarded
        step(1, 3, 0, 0, 0, 1, 8'h55);
        chk("ldb_sram_addr", 32'(bus.sram_addr), 32'h13);
        chk("ldb_zero",   32'(bus.zero), 32'd0);
        chk("ldb_err",    32'(bus.err), 32'd0);
        chk("ldb_res_we", 32'(bus.res_we), 32'd0);
        chk("ldb_done",   32'(bus.done), 32'd0);
        idle();
        idle();

        // first=1 forces carry-in to 0 even with carry register set
        e = '{addr: 1, data: 8'h00, last: 0, cout: 0};
        sb.push_back(e);
        e = '{addr: 0, data: 8'hFF, last: 1, cout: 0};
        sb.push_back(e);
        step(1, 1, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 1, 8'hFF);
        step(0, 0, 0, 0, 1, 1, 8'h01);
        step(0, 0, 1, 1, 0, 1, 8'h7F);
        step(0, 0, 0, 0, 0, 1, 8'h80);
        idle();

        // Random multi-word additions
        for (int n = 0; n < 25; n++) begin
            int L;
            L = $urandom_range(0, 15);
            for (int i = 0; i < 16; i++) begin
                wa[i] = 8'($urandom);
                wb[i] = 8'($urandom);
            end
            do_add(L, 1);
            if ($urandom % 2 == 0) idle();
        end

        repeat (3) idle();
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sram_adder_datapath.md
SRAM_ADDER_DATAPATH -- requirements
Module: sram_adder_datapath

Interface
REQ-001 Parameter DATA_W, default 8, word width of operands and result.
REQ-002 Parameter ADDR_W, default 4, word-index width; max operand length 2^ADDR_W words.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 reset  in  1  reset, asynchronous, active-high.
REQ-005 load  in  1  start pulse; captures len and initialises the datapath.
REQ-006 len  in  ADDR_W  operand length minus one (0 = one word).
REQ-007 first  in  1  from controller: current operation is the first word; carry-in forced to 0.
REQ-008 sel  in  1  from controller: 1 = operand A phase, 0 = operand B phase.
REQ-009 addr_minus_en  in  1  from controller: decrement word index this cycle.
REQ-010 sram_rvalid  in  1  SRAM read data valid (one cycle after the read enable).
REQ-011 sram_rdata  in  DATA_W  SRAM read data.
REQ-012 sram_addr  out  ADDR_W+1  SRAM address; MSB = bank (0 = A, 1 = B), LSBs = word index.
REQ-013 zero  out  1  to controller: word index equals 0.
REQ-014 res_we  out  1  result write strobe, one cycle per result word.
REQ-015 res_addr  out  ADDR_W  result word index.
REQ-016 res_data  out  DATA_W  result word.
REQ-017 carry_out  out  1  final carry, valid from done until the next load.
REQ-018 done  out  1  one-cycle pulse after the last result word is written.
REQ-019 err  out  1  sticky: decrement requested while index is 0.

Function
REQ-020 idx register SHALL load len on load; word order: index len = least significant word, index 0 = most significant word.
REQ-021 sram_addr SHALL be combinational {~sel, idx}.
REQ-022 zero SHALL be combinational (idx == 0).
REQ-023 addr_minus_en with idx > 0 SHALL decrement idx by 1 at the next edge.
REQ-024 addr_minus_en with idx == 0 SHALL hold idx at 0 and set err; no wrap-around.
REQ-025 sram_rvalid with sel=1 SHALL capture sram_rdata into op_a register.
REQ-026 sram_rvalid with sel=0 SHALL compute {c, s} = op_a + sram_rdata + cin, with cin = 0 if first_q else carry register; arithmetic width DATA_W+1.
REQ-027 first_q SHALL be set by load or by first=1, and cleared by each B-phase sum.
REQ-028 A B-phase sum SHALL register res_we=1, res_data=s, res_addr=idx (pre-decrement value), carry=c, all at the next edge.
REQ-029 res_we SHALL be high for exactly one cycle per B-phase sum.
REQ-030 A B-phase sum with idx == 0 SHALL register done=1 for one cycle (same cycle as the final res_we) and latch carry_out=c.
REQ-031 load coinciding with sram_rvalid SHALL take priority: idx=len, carry=0, first_q=1, err=0; the sum is discarded and no res_we or done is issued.
REQ-032 addr_minus_en in the same cycle as a B-phase sum SHALL apply the decrement after the pre-decrement idx is used for res_addr.
REQ-033 sram_rvalid with no prior load SHALL operate on the reset-state registers; no lock-up.

Reset
REQ-034 reset SHALL clear, asynchronously: idx=0, op_a=0, carry=0, first_q=1, res_we=0, res_addr=0, res_data=0, carry_out=0, done=0, err=0; zero therefore reads 1.
REQ-035 reset asserted mid-operation SHALL abort the addition with no further res_we until a new load and a new sum.

Verification
REQ-036 Scenario: load, len=0; A=0xFF, B=0x01 -> res_we once, res_addr=0, res_data=0x00, done=1, carry_out=1.
REQ-037 Scenario: len=1; A words {idx1=0xF0, idx0=0x01}, B words {idx1=0x20, idx0=0x02} -> res idx1=0x10, idx0=0x04 (carry propagated), carry_out=0.
REQ-038 Scenario: addr_minus_en pulsed 3 times at idx=1 -> idx=0, zero=1, err=1, idx does not wrap to 0xF.
REQ-039 Scenario: load and a B-phase sram_rvalid in the same cycle -> no res_we, no done, idx=len, carry=0.
REQ-040 Scenario: reset asserted between the A and B reads -> all outputs at reset values immediately; the following B rvalid without load computes 0x00+rdata.
REQ-041 Scenario: first=1 with carry register=1 -> cin=0; 0x7F+0x80 gives res_data=0xFF, carry=0.
